div: RTL and testbench

DIV -- requirements
Module: div

---
 rtl/div_pkg.sv | 29 ++
 rtl/div.sv | 146 ++++++++++++++
 tb/tb_div.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: bus widths, handshake
// levels, FSM state encoding and a small magnitude helper.
package div_pkg;

    localparam int RegBus       = 32;
    localparam int DoubleRegBus = 64;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    // Two's complement magnitude of a value when it is treated as signed.
    function automatic logic [RegBus-1:0] abs_val(input logic               is_signed,
                                                  input logic [RegBus-1:0] value);
        if (is_signed && value[RegBus-1]) begin
            return ~value + 32'd1;
        end
        return value;
    endfunction

endpackage

// File: rtl/div.sv
// Radix-2 restoring divider. One quotient bit is produced per cycle.
// Signed operands are divided as magnitudes and the signs are fixed up on
// the last step. The result is held until the requester drops start_i.
module div
    import div_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    signed_div_i,
    input  logic [RegBus-1:0]       opdata1_i,
    input  logic [RegBus-1:0]       opdata2_i,
    input  logic                    start_i,
    input  logic                    annul_i,
    output logic [DoubleRegBus-1:0] result_o,
    output logic                    ready_o
);

    div_state_e        state;
    div_state_e        state_next;
    logic [4:0]        cnt;
    logic [RegBus-1:0] divisor;
    logic [RegBus-1:0] rem;
    logic [RegBus-1:0] quo;
    logic              neg_q;
    logic              neg_r;

    logic [RegBus:0]   partial;
    logic [RegBus:0]   diff;
    logic              fits;
    logic [RegBus-1:0] rem_step;
    logic [RegBus-1:0] quo_step;
    logic [RegBus-1:0] rem_fix;
    logic [RegBus-1:0] quo_fix;
    logic              accept;

    assign accept = (start_i == DivStart) && !annul_i;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor; bit 32 of the difference is the borrow.
    always_comb begin
        partial  = {rem, quo[RegBus-1]};
        diff     = partial - {1'b0, divisor};
        fits     = ~diff[RegBus];
        rem_step = fits ? diff[RegBus-1:0] : partial[RegBus-1:0];
        quo_step = {quo[RegBus-2:0], fits};
        rem_fix  = neg_r ? (~rem_step + 32'd1) : rem_step;
        quo_fix  = neg_q ? (~quo_step + 32'd1) : quo_step;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= DivFree;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic for the request / iterate / hold handshake.
    always_comb begin
        state_next = state;
        case (state)
            DivFree: begin
                if (accept) begin
                    state_next = (opdata2_i == '0) ? DivByZero : DivOn;
                end
            end
            DivByZero: begin
                state_next = annul_i ? DivFree : DivEnd;
            end
            DivOn: begin
                if (annul_i) begin
                    state_next = DivFree;
                end else if (cnt == 5'd31) begin
                    state_next = DivEnd;
                end
            end
            DivEnd: begin
                if (start_i == DivStop) begin
                    state_next = DivFree;
                end
            end
            default: state_next = DivFree;
        endcase
    end

    // Datapath: operand capture, iteration, sign fix-up and result hold.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt      <= '0;
            divisor  <= '0;
            rem      <= '0;
            quo      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            ready_o  <= DivResultNotReady;
            result_o <= '0;
        end else begin
            case (state)
                DivFree: begin
                    cnt      <= '0;
                    ready_o  <= DivResultNotReady;
                    result_o <= '0;
                    if (accept && (opdata2_i != '0)) begin
                        divisor <= abs_val(signed_div_i, opdata2_i);
                        quo     <= abs_val(signed_div_i, opdata1_i);
                        rem     <= '0;
                        neg_q   <= signed_div_i && (opdata1_i[RegBus-1] != opdata2_i[RegBus-1]);
                        neg_r   <= signed_div_i && opdata1_i[RegBus-1];
                    end
                end
                DivByZero: begin
                    rem <= '0;
                    quo <= '0;
                end
                DivOn: begin
                    if (annul_i) begin
                        cnt <= '0;
                    end else if (cnt == 5'd31) begin
                        cnt <= '0;
                        rem <= rem_fix;
                        quo <= quo_fix;
                    end else begin
                        cnt <= cnt + 5'd1;
                        rem <= rem_step;
                        quo <= quo_step;
                    end
                end
                DivEnd: begin
                    if (start_i == DivStop) begin
                        ready_o  <= DivResultNotReady;
                        result_o <= '0;
                    end else begin
                        ready_o  <= DivResultReady;
                        result_o <= {rem, quo};
                    end
                end
                default: begin
                    ready_o  <= DivResultNotReady;
                    result_o <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div.sv
// Self-checking bench for the iterative divider: directed vector table,
// annul and reset sequences, and random operands against an arithmetic model.
module tb_div;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int checks;
    int errors;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] expected;
    } vec_t;

    div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: plain 64-bit arithmetic, truncating division, remainder
    // takes the dividend's sign; zero divisor yields zero.
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
    endtask

    // Full request: accept, scramble operands, wait for ready, check
    // latency/result, hold with an ignored annul pulse, then release.
    task automatic run_div(input string name, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] expected);
        int lat;
        apply_stimulus(sgn, a, b);
        @(posedge clk);
        #1;
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = 1'($urandom_range(0, 1));
        lat = 0;
        while (!ready_o && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_output({name, " latency"}, 64'(lat), (b == 32'd0) ? 64'd2 : 64'd33);
        check_output({name, " result"}, result_o, expected);
        for (int i = 0; i < 3; i++) begin
            annul_i = (i == 0);
            @(posedge clk);
            #1;
            annul_i = 1'b0;
            check_output({name, " hold"}, {result_o[62:0], ready_o}, {expected[62:0], 1'b1});
        end
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check_output({name, " release"}, {result_o[62:0], ready_o}, 64'd0);
    endtask

    initial begin
        vec_t        vecs[$];
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        logic        seen_ready;

        checks       = 0;
        errors       = 0;
        rst          = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        start_i      = 1'b0;
        annul_i      = 1'b0;

        vecs.push_back('{1'b0, 32'd100,        32'd7,          64'h00000002_0000000E});
        vecs.push_back('{1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD});
        vecs.push_back('{1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD});
        vecs.push_back('{1'b0, 32'd5,          32'd0,          64'h0});
        vecs.push_back('{1'b1, 32'd5,          32'd0,          64'h0});
        vecs.push_back('{1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000});
        vecs.push_back('{1'b0, 32'h80000000,   32'hFFFFFFFF,   64'h80000000_00000000});
        vecs.push_back('{1'b0, 32'hFFFFFFFF,   32'h10,         64'h0000000F_0FFFFFFF});
        vecs.push_back('{1'b1, 32'hFFFFFFFF,   32'hFFFFFFFF,   64'h00000000_00000001});
        vecs.push_back('{1'b0, 32'd3,          32'd9,          64'h00000003_00000000});

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check_output("reset outputs", {result_o[62:0], ready_o}, 64'd0);
        rst = 1'b1;

        // Directed table.
        foreach (vecs[i]) begin
            run_div($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].expected);
        end

        // Annul mid-division: no ready for that request, then a clean request.
        apply_stimulus(1'b0, 32'd1000, 32'd3);
        repeat (11) @(posedge clk);
        #1;
        annul_i = 1'b1;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        annul_i = 1'b0;
        seen_ready = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            seen_ready |= ready_o;
        end
        check_output("annul no ready", {63'd0, seen_ready}, 64'd0);
        run_div("after annul", 1'b0, 32'hFFFFFFFF, 32'h10, 64'h0000000F_0FFFFFFF);

        // Annul during the divide-by-zero cycle.
        apply_stimulus(1'b1, 32'd5, 32'd0);
        @(posedge clk);
        #1;
        annul_i = 1'b1;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        annul_i = 1'b0;
        seen_ready = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            seen_ready |= ready_o;
        end
        check_output("annul by zero", {63'd0, seen_ready}, 64'd0);

        // Reset mid-division, then a normal request.
        apply_stimulus(1'b0, 32'd100, 32'd7);
        repeat (21) @(posedge clk);
        #1;
        rst     = 1'b0;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check_output("mid reset outputs", {result_o[62:0], ready_o}, 64'd0);
        rst = 1'b1;
        run_div("after reset", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);

        // Random operands against the model.
        for (int n = 0; n < 40; n++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'($urandom_range(1, 15));
                1:       rb = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
                2:       rb = ~32'($urandom_range(0, 7));
                default: rb = $urandom;
            endcase
            run_div($sformatf("rand%0d", n), rs, ra, rb, ref_div(rs, ra, rb));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
